// File: rtl/xadc_drp_sampler_if.sv
// XADC event and DRP read bus between the sampler (master) and the XADC wizard (slave).
interface xadc_drp_sampler_if;
   logic        eoc;
   logic [4:0]  channel;
   logic        drp_den;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_do;
   logic        drp_drdy;

   modport master (input eoc, channel, drp_do, drp_drdy, output drp_den, drp_daddr);
   modport slave  (output eoc, channel, drp_do, drp_drdy, input drp_den, drp_daddr);
endinterface

// File: rtl/xadc_drp_sampler.sv
// Turns XADC end-of-conversion events into DRP reads for two aux channels, with timeout and drop count.
// Optional power-of-two averaging is compiled in with `define XADC_DRP_SAMPLER_AVG_EN.
module xadc_drp_sampler #(
   parameter logic [6:0]  CH0_ADDR = 7'h1C,
   parameter logic [6:0]  CH1_ADDR = 7'h10,
   parameter int unsigned TIMEOUT  = 63,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic                clk,
   input  logic                rst,
   xadc_drp_sampler_if.master  bus,
   input  logic [1:0]          ch_en_i,
   output logic [11:0]         sample0_o,
   output logic [11:0]         sample1_o,
   output logic [1:0]          sample_valid_o,
   output logic                timeout_err_o,
   output logic [7:0]          drop_cnt_o,
   output logic                busy_o
);
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   if (TIMEOUT < 1 || AVG_LOG2 < 1) begin : g_bad_cfg
      $error("xadc_drp_sampler: TIMEOUT and AVG_LOG2 must be at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_STORE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             tgt_q;
   logic [11:0]      data_q;
   logic             den_q;
   logic [6:0]       daddr_q;
   logic [1:0][11:0] sample_q;
   logic [1:0]       valid_q;
   logic             to_q;
   logic [7:0]       drop_q, drop_d;
   logic             hit0, hit1;
   logic             unused_lsb;

   assign hit0 = bus.eoc && (bus.channel == CH0_ADDR[4:0]) && ch_en_i[0];
   assign hit1 = bus.eoc && (bus.channel == CH1_ADDR[4:0]) && ch_en_i[1];
   assign unused_lsb = ^bus.drp_do[3:0];

   // Only events that would have started a transaction count as lost.
   always_comb begin
      drop_d = drop_q;
      if ((state_q != S_IDLE) && (hit0 || hit1) && (drop_q != 8'hFF))
         drop_d = drop_q + 8'd1;
   end

`ifdef XADC_DRP_SAMPLER_AVG_EN
   localparam int unsigned AW = 12 + AVG_LOG2;
   logic [1:0][AW-1:0]       acc_q;
   logic [1:0][AVG_LOG2-1:0] acnt_q;
   logic [AW-1:0]            acc_d;

   assign acc_d = acc_q[tgt_q] + AW'(data_q);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         tgt_q    <= 1'b0;
         data_q   <= '0;
         den_q    <= 1'b0;
         daddr_q  <= CH0_ADDR;
         sample_q <= '0;
         valid_q  <= '0;
         to_q     <= 1'b0;
         drop_q   <= '0;
`ifdef XADC_DRP_SAMPLER_AVG_EN
         acc_q    <= '0;
         acnt_q   <= '0;
`endif
      end else begin
         den_q   <= 1'b0;
         valid_q <= '0;
         to_q    <= 1'b0;
         drop_q  <= drop_d;
         case (state_q)
            S_IDLE: begin
               if (hit0) begin
                  tgt_q   <= 1'b0;
                  daddr_q <= CH0_ADDR;
                  den_q   <= 1'b1;
                  state_q <= S_REQ;
               end else if (hit1) begin
                  tgt_q   <= 1'b1;
                  daddr_q <= CH1_ADDR;
                  den_q   <= 1'b1;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // drdy on the final count still wins over the timeout.
               if (bus.drp_drdy) begin
                  data_q  <= bus.drp_do[15:4];
                  state_q <= S_STORE;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  to_q    <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_STORE: begin
`ifdef XADC_DRP_SAMPLER_AVG_EN
               if (acnt_q[tgt_q] == '1) begin
                  sample_q[tgt_q] <= acc_d[AW-1 -: 12];
                  valid_q[tgt_q]  <= 1'b1;
                  acc_q[tgt_q]    <= '0;
               end else begin
                  acc_q[tgt_q] <= acc_d;
               end
               acnt_q[tgt_q] <= acnt_q[tgt_q] + AVG_LOG2'(1);
`else
               sample_q[tgt_q] <= data_q;
               valid_q[tgt_q]  <= 1'b1;
`endif
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
`ifdef XADC_DRP_SAMPLER_AVG_EN
         // A disabled channel restarts its window from empty when re-enabled.
         for (int i = 0; i < 2; i++) begin
            if (!ch_en_i[i]) begin
               acc_q[i]  <= '0;
               acnt_q[i] <= '0;
            end
         end
`endif
      end
   end

   assign bus.drp_den     = den_q;
   assign bus.drp_daddr   = daddr_q;
   assign sample0_o       = sample_q[0];
   assign sample1_o       = sample_q[1];
   assign sample_valid_o  = valid_q;
   assign timeout_err_o   = to_q;
   assign drop_cnt_o      = drop_q;
   assign busy_o          = (state_q != S_IDLE);
endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Directed bench for xadc_drp_sampler: stimulus pushes expected sample/timeout events, a monitor checks them.
module tb_xadc_drp_sampler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  ch_en = 2'b00;
   logic [11:0] sample0, sample1;
   logic [1:0]  sample_valid;
   logic        timeout_err, busy;
   logic [7:0]  drop_cnt;
   int          nvec = 0;
   int          nbad = 0;

   typedef struct {
      logic [1:0]  v;
      logic        to;
      logic [11:0] s0;
      logic [11:0] s1;
   } exp_t;
   exp_t sbq[$];

   xadc_drp_sampler_if bus();

   xadc_drp_sampler dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .ch_en_i        (ch_en),
      .sample0_o      (sample0),
      .sample1_o      (sample1),
      .sample_valid_o (sample_valid),
      .timeout_err_o  (timeout_err),
      .drop_cnt_o     (drop_cnt),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] v, input logic to, input logic [11:0] s0, input logic [11:0] s1);
      exp_t e;
      e.v = v; e.to = to; e.s0 = s0; e.s1 = s1;
      sbq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every strobe the DUT raises must match the next queued expectation.
   always @(negedge clk) begin
      if (!rst && (sample_valid != 2'b00 || timeout_err)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_event", {29'd0, sample_valid, timeout_err}, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("ev_valid", sample_valid, e.v);
            chk("ev_timeout", timeout_err, e.to);
            chk("ev_sample0", sample0, e.s0);
            chk("ev_sample1", sample1, e.s1);
         end
      end
   end

   task automatic chk_reset_state();
      chk("rst_den", bus.drp_den, 0);
      chk("rst_daddr", bus.drp_daddr, 7'h1C);
      chk("rst_sample0", sample0, 0);
      chk("rst_sample1", sample1, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_busy", busy, 0);
   endtask

   // eoc -> den -> (dly cycles) drdy -> STORE -> sample; optional overrun pulses in WAIT and eoc in STORE.
   task automatic txn(input logic [4:0] code, input logic [15:0] data, input int dly,
                      input logic [6:0] exp_addr, input logic [1:0] exp_v, input bit ovr, input bit st_eoc);
      bus.eoc = 1'b1; bus.channel = code;
      step();
      bus.eoc = 1'b0;
      chk("den_hi", bus.drp_den, 1);
      chk("daddr", bus.drp_daddr, exp_addr);
      for (int i = 0; i < dly; i++) begin
         step();
         if (i == 0) chk("den_pulse", bus.drp_den, 0);
         bus.eoc     = ovr && (i inside {1, 3, 5, 7});
         bus.channel = (i == 7) ? 5'h03 : code;
      end
      bus.eoc = 1'b0; bus.drp_drdy = 1'b1; bus.drp_do = data;
      step();
      bus.drp_drdy = 1'b0; bus.drp_do = '0; bus.eoc = st_eoc; bus.channel = code;
      step();
      bus.eoc = 1'b0;
      chk("valid_lat", sample_valid, exp_v);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bus.eoc = 1'b0; bus.channel = '0; bus.drp_do = '0; bus.drp_drdy = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_reset_state();

`ifdef XADC_DRP_SAMPLER_AVG_EN
      ch_en = 2'b10;
      txn(5'h10, 16'h1000, 1, 7'h10, 2'b00, 0, 0);
      txn(5'h10, 16'h2000, 1, 7'h10, 2'b00, 0, 0);
      txn(5'h10, 16'h3000, 1, 7'h10, 2'b00, 0, 0);
      push(2'b10, 1'b0, 12'h000, 12'h280);
      txn(5'h10, 16'h4000, 1, 7'h10, 2'b10, 0, 0);
      chk("avg_sample1", sample1, 12'h280);
`else
      ch_en = 2'b01;
      bus.eoc = 1'b1; bus.channel = 5'h03;
      step();
      bus.eoc = 1'b0;
      chk("filt_code_den", bus.drp_den, 0);
      chk("filt_code_busy", busy, 0);
      bus.eoc = 1'b1; bus.channel = 5'h10;
      step();
      bus.eoc = 1'b0;
      chk("filt_dis_den", bus.drp_den, 0);
      chk("filt_dis_busy", busy, 0);

      push(2'b01, 1'b0, 12'hABC, 12'h000);
      txn(5'h1C, 16'hABC0, 1, 7'h1C, 2'b01, 0, 0);
      chk("ch0_sample1_idle", sample1, 12'h000);

      ch_en = 2'b11;
      push(2'b10, 1'b0, 12'hABC, 12'h5A5);
      txn(5'h10, 16'h5A5F, 1, 7'h10, 2'b10, 0, 0);
      chk("drop_none", drop_cnt, 0);

      // No drdy: abandon after TIMEOUT cycles of waiting.
      ch_en = 2'b01;
      push(2'b00, 1'b1, 12'hABC, 12'h5A5);
      bus.eoc = 1'b1; bus.channel = 5'h1C;
      step();
      bus.eoc = 1'b0;
      chk("to_den", bus.drp_den, 1);
      lat = -1;
      for (int k = 1; k <= 80; k++) begin
         step();
         if (timeout_err) begin
            lat = k;
            break;
         end
      end
      chk("to_latency", lat, 64);
      step();
      chk("to_busy_after", busy, 0);
      push(2'b01, 1'b0, 12'h123, 12'h5A5);
      txn(5'h1C, 16'h1230, 3, 7'h1C, 2'b01, 0, 0);

      push(2'b01, 1'b0, 12'hFFF, 12'h5A5);
      txn(5'h1C, 16'hFFF0, 63, 7'h1C, 2'b01, 0, 0);

      push(2'b01, 1'b0, 12'h444, 12'h5A5);
      txn(5'h1C, 16'h4440, 10, 7'h1C, 2'b01, 1, 0);
      chk("drop_overrun", drop_cnt, 3);

      push(2'b01, 1'b0, 12'h555, 12'h5A5);
      txn(5'h1C, 16'h5550, 1, 7'h1C, 2'b01, 0, 1);
      chk("drop_store", drop_cnt, 4);
`endif

      // Reset while waiting on channel 1; the late drdy must be ignored.
      ch_en = 2'b11;
      bus.eoc = 1'b1; bus.channel = 5'h10;
      step();
      bus.eoc = 1'b0;
      chk("rw_den", bus.drp_den, 1);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.drp_drdy = 1'b1; bus.drp_do = 16'hEEE0;
      step();
      bus.drp_drdy = 1'b0; bus.drp_do = '0;
      step();
      step();
      chk_reset_state();
      push(2'b01, 1'b0, 12'h777, 12'h000);
      txn(5'h1C, 16'h7770, 2, 7'h1C, 2'b01, 0, 0);

      step();
      chk("sb_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
